// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT,
    RESP
  } cache_state_e;

  function automatic int unsigned offWidth(input int unsigned wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  function automatic int unsigned idxWidth(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tagWidth(input int unsigned addrW,
                                           input int unsigned sets,
                                           input int unsigned wordsPerLine);
    return addrW - $clog2(sets) - $clog2(wordsPerLine);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set tag, valid, dirty and line storage with tag compare.
module cache_way #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 4,
  parameter int unsigned IDX_W  = 9,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IDX_W-1:0]                 idx,
  input  logic [TAG_W-1:0]                 cmpTag,
  output logic                             tagMatch,
  output logic                             isValid,
  output logic                             isDirty,
  output logic [TAG_W-1:0]                 tagOut,
  output logic [DATA_W*(2**OFF_W)-1:0]     lineOut,
  input  logic                             fillEn,
  input  logic [TAG_W-1:0]                 fillTag,
  input  logic [DATA_W*(2**OFF_W)-1:0]     fillLine,
  input  logic                             fillDirty,
  input  logic                             wordEn,
  input  logic [OFF_W-1:0]                 wordOff,
  input  logic [DATA_W-1:0]                wordData,
  input  logic                             invEn
);

  localparam int unsigned SETS   = 2**IDX_W;
  localparam int unsigned LINE_W = DATA_W * (2**OFF_W);

  logic [SETS-1:0]   validBits;
  logic [SETS-1:0]   dirtyBits;
  logic [TAG_W-1:0]  tagMem  [SETS];
  logic [LINE_W-1:0] lineMem [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validBits <= '0;
      dirtyBits <= '0;
    end else if (invEn) begin
      validBits[idx] <= 1'b0;
      dirtyBits[idx] <= 1'b0;
    end else if (fillEn) begin
      validBits[idx] <= 1'b1;
      dirtyBits[idx] <= fillDirty;
    end else if (wordEn) begin
      dirtyBits[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagMem[idx]  <= fillTag;
      lineMem[idx] <= fillLine;
    end else if (wordEn) begin
      lineMem[idx][wordOff*DATA_W +: DATA_W] <= wordData;
    end
  end

  assign isValid  = validBits[idx];
  assign isDirty  = dirtyBits[idx];
  assign tagOut   = tagMem[idx];
  assign lineOut  = lineMem[idx];
  assign tagMatch = validBits[idx] && (tagMem[idx] == cmpTag);

endmodule

// File: rtl/set_assoc_cache.sv
// Blocking write-back, write-allocate cache with 1 or 2 ways and per-set LRU.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned SETS           = 512,
  parameter int unsigned WAYS           = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        cpu_req_valid,
  output logic                                        cpu_req_ready,
  input  logic                                        cpu_req_write,
  input  logic [ADDR_W-1:0]                           cpu_req_addr,
  input  logic [DATA_W-1:0]                           cpu_req_wdata,
  output logic                                        cpu_resp_valid,
  output logic [DATA_W-1:0]                           cpu_resp_rdata,
  output logic                                        cpu_resp_hit,
  output logic                                        mem_req_valid,
  input  logic                                        mem_req_ready,
  output logic                                        mem_req_write,
  output logic [ADDR_W-$clog2(WORDS_PER_LINE)-1:0]    mem_req_addr,
  output logic [DATA_W*WORDS_PER_LINE-1:0]            mem_req_wline,
  input  logic                                        mem_resp_valid,
  input  logic [DATA_W*WORDS_PER_LINE-1:0]            mem_resp_rline,
  output logic [31:0]                                 hit_cnt,
  output logic [31:0]                                 miss_cnt
);

  localparam int unsigned OFF_W  = offWidth(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = idxWidth(SETS);
  localparam int unsigned TAG_W  = tagWidth(ADDR_W, SETS, WORDS_PER_LINE);
  localparam int unsigned LINE_W = DATA_W * WORDS_PER_LINE;

  cache_state_e state, nextState;

  logic              reqWrite;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              reqHit;
  logic              victimWay;
  logic [SETS-1:0]   lruBits;

  logic [TAG_W-1:0]  reqTag;
  logic [IDX_W-1:0]  reqIdx;
  logic [OFF_W-1:0]  reqOff;

  logic [1:0]        wayHit, wayValid, wayDirty;
  logic [1:0]        wordEn, fillEn, invEn;
  logic [TAG_W-1:0]  wayTag  [2];
  logic [LINE_W-1:0] wayLine [2];

  logic              hit, hitWay, victimSel, victimDirty;
  logic [LINE_W-1:0] fillLine;

  assign reqTag = reqAddr[ADDR_W-1 -: TAG_W];
  assign reqIdx = reqAddr[OFF_W +: IDX_W];
  assign reqOff = reqAddr[OFF_W-1:0];

  // Way slots beyond WAYS are tied off as permanently invalid.
  for (genvar w = 0; w < 2; w++) begin : gWay
    if (w < WAYS) begin : gInst
      cache_way #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
      ) uWay (
        .clk       (clk),
        .rst       (rst),
        .idx       (reqIdx),
        .cmpTag    (reqTag),
        .tagMatch  (wayHit[w]),
        .isValid   (wayValid[w]),
        .isDirty   (wayDirty[w]),
        .tagOut    (wayTag[w]),
        .lineOut   (wayLine[w]),
        .fillEn    (fillEn[w]),
        .fillTag   (reqTag),
        .fillLine  (fillLine),
        .fillDirty (reqWrite),
        .wordEn    (wordEn[w]),
        .wordOff   (reqOff),
        .wordData  (reqWdata),
        .invEn     (invEn[w])
      );
    end else begin : gTie
      assign wayHit[w]   = 1'b0;
      assign wayValid[w] = 1'b0;
      assign wayDirty[w] = 1'b0;
      assign wayTag[w]   = '0;
      assign wayLine[w]  = '0;
    end
  end

  assign hit         = |wayHit;
  assign hitWay      = wayHit[1];
  assign victimDirty = wayValid[victimSel] & wayDirty[victimSel];

  always_comb begin
    victimSel = 1'b0;
    if (WAYS > 1) begin
      if (!wayValid[0])      victimSel = 1'b0;
      else if (!wayValid[1]) victimSel = 1'b1;
      else                   victimSel = lruBits[reqIdx];
    end
  end

  always_comb begin
    fillLine = mem_resp_rline;
    if (reqWrite) fillLine[reqOff*DATA_W +: DATA_W] = reqWdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    wordEn    = '0;
    fillEn    = '0;
    invEn     = '0;
    case (state)
      IDLE:      if (cpu_req_valid) nextState = COMPARE;
      COMPARE: begin
        if (hit) begin
          nextState      = RESP;
          wordEn[hitWay] = reqWrite;
        end else if (victimDirty) begin
          nextState = WB_REQ;
        end else begin
          nextState = FILL_REQ;
        end
      end
      WB_REQ: if (mem_req_ready) begin
        nextState        = FILL_REQ;
        invEn[victimWay] = 1'b1;
      end
      FILL_REQ:  if (mem_req_ready) nextState = FILL_WAIT;
      FILL_WAIT: if (mem_resp_valid) begin
        nextState         = RESP;
        fillEn[victimWay] = 1'b1;
      end
      RESP:      nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  assign cpu_req_ready = (state == IDLE);

  // LRU bit names the way that was not touched by the latest access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        lruBits <= '0;
    else if (state == COMPARE && hit) lruBits[reqIdx] <= ~hitWay;
    else if (|fillEn)               lruBits[reqIdx] <= ~victimWay;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reqWrite       <= 1'b0;
      reqAddr        <= '0;
      reqWdata       <= '0;
      reqHit         <= 1'b0;
      victimWay      <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_rdata <= '0;
      cpu_resp_hit   <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_write  <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wline  <= '0;
      hit_cnt        <= '0;
      miss_cnt       <= '0;
    end else begin
      cpu_resp_valid <= (state == RESP);
      case (state)
        IDLE: if (cpu_req_valid) begin
          reqWrite <= cpu_req_write;
          reqAddr  <= cpu_req_addr;
          reqWdata <= cpu_req_wdata;
        end
        COMPARE: begin
          reqHit    <= hit;
          victimWay <= victimSel;
          if (hit) begin
            cpu_resp_rdata <= wayLine[hitWay][reqOff*DATA_W +: DATA_W];
          end else begin
            mem_req_valid <= 1'b1;
            if (victimDirty) begin
              mem_req_write <= 1'b1;
              mem_req_addr  <= {wayTag[victimSel], reqIdx};
              mem_req_wline <= wayLine[victimSel];
            end else begin
              mem_req_write <= 1'b0;
              mem_req_addr  <= reqAddr[ADDR_W-1:OFF_W];
            end
          end
        end
        // Writeback acceptance rolls straight into the fill request.
        WB_REQ: if (mem_req_ready) begin
          mem_req_write <= 1'b0;
          mem_req_addr  <= reqAddr[ADDR_W-1:OFF_W];
        end
        FILL_REQ:  if (mem_req_ready) mem_req_valid <= 1'b0;
        FILL_WAIT: if (mem_resp_valid) cpu_resp_rdata <= mem_resp_rline[reqOff*DATA_W +: DATA_W];
        RESP: begin
          cpu_resp_hit <= reqHit;
          if (reqHit) hit_cnt  <= hit_cnt + 32'd1;
          else        miss_cnt <= miss_cnt + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache with a cycle-stepped memory model.
module tb_set_assoc_cache;

  localparam int unsigned LINE_W  = 512;
  localparam int unsigned LADDR_W = 13;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [16:0]        cpu_req_addr;
  logic [31:0]        cpu_req_wdata;
  logic               cpu_resp_valid, cpu_resp_hit;
  logic [31:0]        cpu_resp_rdata;
  logic               mem_req_valid, mem_req_ready, mem_req_write;
  logic [LADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0]  mem_req_wline;
  logic               mem_resp_valid;
  logic [LINE_W-1:0]  mem_resp_rline;
  logic [31:0]        hit_cnt, miss_cnt;

  set_assoc_cache #(
    .ADDR_W         (17),
    .DATA_W         (32),
    .WORDS_PER_LINE (16),
    .SETS           (512),
    .WAYS           (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cpu_resp_hit   (cpu_resp_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wline  (mem_req_wline),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rline (mem_resp_rline),
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chkData;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] hits;
    logic [31:0] misses;
  } resp_t;

  typedef struct {
    logic               wr;
    logic [LADDR_W-1:0] lineAddr;
    logic               chkLine;
    logic [LINE_W-1:0]  line;
  } memreq_t;

  resp_t             respQ[$];
  memreq_t           memQ[$];
  logic [LINE_W-1:0] memStore [int unsigned];
  logic [31:0]       expHits = 0, expMisses = 0;
  int unsigned       errCnt = 0, chkCnt = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] refLine(input int unsigned l);
    logic [LINE_W-1:0] v;
    if (memStore.exists(l)) return memStore[l];
    for (int unsigned j = 0; j < 16; j++) v[j*32 +: 32] = l*16 + j;
    return v;
  endfunction

  task automatic expectResp(input logic chkData, input logic [31:0] rdata, input logic hit);
    resp_t r;
    if (hit) expHits++; else expMisses++;
    r.chkData = chkData; r.rdata = rdata; r.hit = hit;
    r.hits = expHits; r.misses = expMisses;
    respQ.push_back(r);
  endtask

  task automatic expectMem(input logic wr, input int unsigned lineAddr,
                           input logic chkLine, input logic [LINE_W-1:0] line);
    memreq_t m;
    m.wr = wr; m.lineAddr = LADDR_W'(lineAddr); m.chkLine = chkLine; m.line = line;
    memQ.push_back(m);
  endtask

  task automatic checkIdle(input string where);
    chk({where, ".reqReady"},  cpu_req_ready, 1);
    chk({where, ".respValid"}, cpu_resp_valid, 0);
    chk({where, ".rdata"},     cpu_resp_rdata, 0);
    chk({where, ".hit"},       cpu_resp_hit, 0);
    chk({where, ".memValid"},  mem_req_valid, 0);
    chk({where, ".memWrite"},  mem_req_write, 0);
    chk({where, ".memAddr"},   mem_req_addr, 0);
    chk({where, ".memLine"},   mem_req_wline, 0);
    chk({where, ".hitCnt"},    hit_cnt, 0);
    chk({where, ".missCnt"},   miss_cnt, 0);
  endtask

  // Issue one request at a negedge and act as memory until the response.
  task automatic doReq(input logic wr, input logic [16:0] addr, input logic [31:0] wdata,
                       input int unsigned rdyDelay, input int unsigned fillLat,
                       input logic abortFill, input int expLat);
    int unsigned        k, waitCnt, fillDue;
    logic               done, acked, fillPend, abortNow;
    logic [LADDR_W-1:0] fillAddr, sA;
    logic               sW;
    logic [LINE_W-1:0]  sL;
    resp_t              r;
    memreq_t            m;
    chk("reqReadyIdle", cpu_req_ready, 1);
    cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = addr; cpu_req_wdata = wdata;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_write = 1'($urandom);
    cpu_req_addr  = 17'($urandom);
    cpu_req_wdata = $urandom;
    done = 0; acked = 0; fillPend = 0; abortNow = 0; waitCnt = 0; fillDue = 0;
    fillAddr = '0; sA = '0; sW = 0; sL = '0;
    k = 1;
    while (!done && k <= 200) begin
      mem_resp_valid = 1'b0;
      if (cpu_resp_valid) begin
        done = 1;
        if (respQ.size() == 0) chk("respUnexpected", 1, 0);
        else begin
          r = respQ.pop_front();
          if (r.chkData) chk("rdata", cpu_resp_rdata, r.rdata);
          chk("respHit", cpu_resp_hit, r.hit);
          chk("hitCnt", hit_cnt, r.hits);
          chk("missCnt", miss_cnt, r.misses);
          if (expLat >= 0) chk("hitLatency", k - 1, expLat);
        end
      end else begin
        chk("busyReady", cpu_req_ready, 0);
        if (acked) begin
          mem_req_ready = 1'b0; acked = 0; waitCnt = 0;
        end else if (mem_req_valid) begin
          if (waitCnt == 0) begin
            sW = mem_req_write; sA = mem_req_addr; sL = mem_req_wline;
          end else begin
            chk("holdWrite", mem_req_write, sW);
            chk("holdAddr", mem_req_addr, sA);
            chk("holdLine", mem_req_wline, sL);
          end
          if (waitCnt >= rdyDelay) begin
            mem_req_ready = 1'b1; acked = 1;
            if (memQ.size() == 0) chk("memUnexpected", 1, 0);
            else begin
              m = memQ.pop_front();
              chk("memWrite", mem_req_write, m.wr);
              chk("memAddr", mem_req_addr, m.lineAddr);
              if (m.chkLine) chk("wbLine", mem_req_wline, m.line);
            end
            if (mem_req_write) memStore[mem_req_addr] = mem_req_wline;
            else begin
              fillPend = !abortFill; fillDue = k + fillLat; fillAddr = mem_req_addr;
              abortNow = abortFill;
            end
          end
          waitCnt++;
        end
        if (fillPend && k == fillDue) begin
          mem_resp_valid = 1'b1; mem_resp_rline = refLine(fillAddr); fillPend = 0;
        end
      end
      if (!done) begin
        @(negedge clk);
        k++;
        if (abortNow) begin mem_req_ready = 1'b0; done = 1; end
      end
    end
    if (!done) chk("respTimeout", 0, 1);
    mem_resp_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expHits = 0; expMisses = 0;
  endtask

  logic [LINE_W-1:0] wbLine;

  initial begin
    rst = 1'b1;
    cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rline = '0;
    repeat (2) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold miss, hit, write hit, read-back, second way, dirty eviction
    expectMem(0, 8, 0, '0);     expectResp(1, 32'd128, 0);  doReq(0, 17'd128, 0, 0, 1, 0, -1);
    expectResp(1, 32'd128, 1);                              doReq(0, 17'd128, 0, 0, 1, 0, 2);
    expectResp(0, 32'd0, 1);                                doReq(1, 17'd129, 32'hDEAD, 0, 1, 0, 2);
    expectResp(1, 32'hDEAD, 1);                             doReq(0, 17'd129, 0, 0, 1, 0, 2);
    expectMem(0, 520, 0, '0);   expectResp(1, 32'd8320, 0); doReq(0, 17'd8320, 0, 0, 3, 0, -1);
    wbLine = refLine(8);
    wbLine[63:32] = 32'hDEAD;
    expectMem(1, 8, 1, wbLine);
    expectMem(0, 1032, 0, '0);  expectResp(1, 32'd16512, 0); doReq(0, 17'd16512, 0, 2, 2, 0, -1);
    expectMem(0, 8, 0, '0);     expectResp(1, 32'hDEAD, 0);  doReq(0, 17'd129, 0, 0, 1, 0, -1);

    // LRU picks the less recently used clean way
    doReset();
    expectMem(0, 8, 0, '0);     expectResp(1, 32'd128, 0);   doReq(0, 17'd128, 0, 0, 1, 0, -1);
    expectMem(0, 520, 0, '0);   expectResp(1, 32'd8320, 0);  doReq(0, 17'd8320, 0, 0, 1, 0, -1);
    expectResp(1, 32'd128, 1);                               doReq(0, 17'd128, 0, 0, 1, 0, 2);
    expectMem(0, 1032, 0, '0);  expectResp(1, 32'd16512, 0); doReq(0, 17'd16512, 0, 0, 1, 0, -1);
    expectResp(1, 32'd128, 1);                               doReq(0, 17'd128, 0, 0, 1, 0, 2);
    expectMem(0, 520, 0, '0);   expectResp(1, 32'd8320, 0);  doReq(0, 17'd8320, 0, 0, 1, 0, -1);

    // Backpressure and long fill latency
    expectMem(0, 16, 0, '0);    expectResp(1, 32'd258, 0);   doReq(0, 17'd258, 0, 5, 7, 0, -1);

    // Reset while waiting for fill data, then a stale fill pulse
    expectMem(0, 32, 0, '0);
    doReq(0, 17'd512, 0, 0, 1, 1, -1);
    rst = 1'b1;
    #1;
    checkIdle("midReset");
    @(negedge clk);
    rst = 1'b0;
    expHits = 0; expMisses = 0;
    mem_resp_valid = 1'b1; mem_resp_rline = refLine(32);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("staleRespValid", cpu_resp_valid, 0);
      chk("staleMemValid", mem_req_valid, 0);
      @(negedge clk);
    end
    expectMem(0, 32, 0, '0);    expectResp(1, 32'd512, 0);   doReq(0, 17'd512, 0, 0, 1, 0, -1);

    chk("memQEmpty", memQ.size(), 0);
    chk("respQEmpty", respQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised 2-way set-associative, write-back, write-allocate cache sitting between a word-addressed CPU port and a line-addressed main-memory port. It generalises the direct-mapped cache to configurable address, data, line and set geometry. It adds LRU replacement, valid/ready handshakes on both sides, tolerance of arbitrary memory latency with backpressure, and hit/miss counters. One request is in flight at a time (blocking cache).

## Interface
- ADDR_W, 17, word address width
- DATA_W, 32, word width
- WORDS_PER_LINE, 16, words per line (power of 2); OFF_W = log2
- SETS, 512, sets (power of 2); IDX_W = log2; TAG_W = ADDR_W-IDX_W-OFF_W (≥1)
- WAYS, 2, 1 or 2 only (1 = direct-mapped, LRU unused)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req_valid  in  1  request present
- cpu_req_ready  out  1  cache can accept
- cpu_req_write  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_W  word address {tag, index, offset}
- cpu_req_wdata  in  DATA_W  write data
- cpu_resp_valid  out  1  one-cycle completion pulse (reads and writes)
- cpu_resp_rdata  out  DATA_W  read data (old word value on writes is don't-care)
- cpu_resp_hit  out  1  request hit
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = line writeback, 0 = line fill
- mem_req_addr  out  ADDR_W-OFF_W  line address
- mem_req_wline  out  DATA_W*WORDS_PER_LINE  writeback data, word 0 in LSBs
- mem_resp_valid  in  1  one-cycle fill-data pulse
- mem_resp_rline  in  DATA_W*WORDS_PER_LINE  fill data
- hit_cnt, miss_cnt  out  32  completed hits/misses; wrap modulo 2^32

## Operation
- FSM: IDLE, COMPARE, WB_REQ, FILL_REQ, FILL_WAIT, RESP.
- IDLE: cpu_req_ready=1; on valid&ready, register write flag, address and wdata; go to COMPARE.
- COMPARE: hit = valid&&tag match in any way.
  - Hit: perform read or write; update LRU; go to RESP.
  - Miss, victim dirty: go to WB_REQ.
  - Miss, victim clean or invalid: go to FILL_REQ.
- Victim selection: first invalid way, way 0 preferred; otherwise the LRU way.
- WB_REQ: mem_req_write=1, address {victim tag, index}, wline = victim data. Hold until mem_req_ready, then clear victim valid and go to FILL_REQ.
- FILL_REQ: mem_req_write=0, address = req line. Hold until ready, then go to FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, install line, tag, valid=1, dirty=0.
  - Write request: merge wdata into the installed line and set dirty=1.
  - Read request: rdata = installed word.
  - Update LRU; go to RESP.
- RESP: cpu_resp_valid=1 for one cycle; hit flag and counters update here; return to IDLE.
- Any write hit sets dirty. LRU bit per set points to the way not most recently accessed.
- mem_resp_valid outside FILL_WAIT is ignored.
- Reset asynchronously clears:
  - all valid, dirty and LRU bits, counters and registered outputs;
  - FSM to IDLE. Data arrays are not reset.
- Reset mid-operation abandons the transaction: no response, mem_req_valid drops immediately, and a later stale fill is ignored.

## Timing
- Reset values: cpu_req_ready=1, cpu_resp_valid=0, cpu_resp_rdata=0, cpu_resp_hit=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_req_wline=0, hit_cnt=0, miss_cnt=0.
- Hit: accepted at edge N, cpu_resp_valid high in cycle after edge N+2. Peak throughput is one request per 3 cycles.
- Clean miss: 4 cycles + mem ready wait + fill latency (≥1).
- Dirty miss adds 1 cycle + ready wait.
- mem_req_* are registered and stable while valid&&!ready.
- cpu_req_ready=0 from acceptance until cycle after RESP.
- The CPU request is sampled only at acceptance.

## Structure
- Package cache_pkg holds:
  - cache_state_e enum (6 states);
  - localparam functions for OFF_W, IDX_W and TAG_W derivation.
- Sub-module cache_way: one way's tag, valid, dirty and line storage, with read-by-index, tag-compare output and line/word write ports. Instantiated WAYS times.
- Top holds the FSM, LRU array, victim mux and counters.

## Test plan
Bench memory word j of line L = L*16+j, with default parameters. Address 128 is set 8, tag 0; 8320 is set 8, tag 1; 16512 is set 8, tag 2.
- Cold read 128: one fill request at line 8, rdata=128, hit=0. Repeat read: hit=1, response 2 cycles after accept, no mem traffic, hit_cnt=1, miss_cnt=1.
- Write 0xDEAD to 129, then read 129: both hits, rdata=0xDEAD, no mem request.
- Continue with reads of 8320 then 16512:
  - 8320 fills way 1;
  - 16512 evicts tag 0: writeback at line 8 with word 1=0xDEAD, then fill of line 1032;
  - read 129 then misses and returns 0xDEAD.
- After reset, read 128, 8320, 128, 16512: the last request evicts 8320 with no writeback. A subsequent read of 128 hits.
- Hold mem_req_ready low for 5 cycles and return the fill 7 cycles after acceptance: mem_req_* stay stable, cpu_req_ready stays 0, correct rdata.
- Assert rst during FILL_WAIT, then pulse mem_resp_valid: no cpu_resp_valid, all outputs at reset values. A following read of the same address misses.
